// File: rtl/dtc_pkg.sv
// rtl/dtc_pkg.sv - shared class-code constants and vote FSM states
package dtc_pkg;

  localparam int CLASS_W     = 3;
  localparam int NUM_CLASSES = 8;

  typedef enum logic [1:0] {
    ST_ACCUM = 2'd0,
    ST_SCAN  = 2'd1,
    ST_EMIT  = 2'd2
  } dtc_state_e;

endpackage

// File: rtl/dtc_vote_collector_if.sv
// rtl/dtc_vote_collector_if.sv - class-result input and vote-result output handshakes
interface dtc_vote_collector_if #(
  parameter int CNT_W = 8
);
  import dtc_pkg::*;

  logic               in_valid;
  logic               in_ready;
  logic [CLASS_W-1:0] in_class;
  logic               flush;
  logic               out_valid;
  logic               out_ready;
  logic [CLASS_W-1:0] out_class;
  logic [CNT_W-1:0]   out_count;
  logic [CNT_W-1:0]   out_total;

  modport master (
    output in_valid, in_class, flush, out_ready,
    input  in_ready, out_valid, out_class, out_count, out_total
  );

  modport slave (
    input  in_valid, in_class, flush, out_ready,
    output in_ready, out_valid, out_class, out_count, out_total
  );

endinterface

// File: rtl/dtc_vote_collector.sv
// rtl/dtc_vote_collector.sv - majority vote over a window of classifier results
module dtc_vote_collector
  import dtc_pkg::*;
#(
  parameter int WINDOW = 16,
  parameter int CNT_W  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  dtc_vote_collector_if.slave  bus
);

  localparam int               IDX_W      = $clog2(NUM_CLASSES) + 1;
  localparam logic [CNT_W-1:0] LAST_TOTAL = CNT_W'(WINDOW - 1);
  localparam logic [IDX_W-1:0] SCAN_END   = IDX_W'(NUM_CLASSES);

  dtc_state_e         state;
  dtc_state_e         state_next;
  logic [CNT_W-1:0]   cnt [NUM_CLASSES];
  logic [CNT_W-1:0]   total;
  logic [CNT_W-1:0]   best;
  logic [CLASS_W-1:0] best_class;
  logic [IDX_W-1:0]   idx;
  logic [CLASS_W-1:0] scan_class;
  logic               out_valid_q;
  logic [CLASS_W-1:0] out_class_q;
  logic [CNT_W-1:0]   out_count_q;
  logic [CNT_W-1:0]   out_total_q;
  logic               accept;
  logic               start_scan;
  logic               scan_done;
  logic               handshake;

  assign scan_class = idx[CLASS_W-1:0];
  assign accept     = bus.in_valid && (state == ST_ACCUM);
  // A flush only closes a window that will hold at least one sample after this edge.
  assign start_scan = (state == ST_ACCUM) &&
                      ((accept && (total == LAST_TOTAL)) ||
                       (bus.flush && (accept || (total != '0))));
  assign scan_done  = (state == ST_SCAN) && (idx == SCAN_END);
  assign handshake  = (state == ST_EMIT) && bus.out_ready;

  assign bus.in_ready  = (state == ST_ACCUM);
  assign bus.out_valid = out_valid_q;
  assign bus.out_class = out_class_q;
  assign bus.out_count = out_count_q;
  assign bus.out_total = out_total_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_ACCUM;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_ACCUM: if (start_scan) state_next = ST_SCAN;
      ST_SCAN:  if (scan_done)  state_next = ST_EMIT;
      ST_EMIT:  if (handshake)  state_next = ST_ACCUM;
      default:                  state_next = ST_ACCUM;
    endcase
  end

  // The scan walks idx 0..7 then spends one more edge latching the result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_CLASSES; i++) cnt[i] <= '0;
      total       <= '0;
      idx         <= '0;
      best        <= '0;
      best_class  <= '0;
      out_valid_q <= 1'b0;
      out_class_q <= '0;
      out_count_q <= '0;
      out_total_q <= '0;
    end else begin
      case (state)
        ST_ACCUM: begin
          if (accept) begin
            cnt[bus.in_class] <= cnt[bus.in_class] + CNT_W'(1);
            total             <= total + CNT_W'(1);
          end
          if (start_scan) begin
            idx        <= '0;
            best       <= '0;
            best_class <= '0;
          end
        end
        ST_SCAN: begin
          if (!scan_done) begin
            if (cnt[scan_class] > best) begin
              best       <= cnt[scan_class];
              best_class <= scan_class;
            end
            idx <= idx + IDX_W'(1);
          end else begin
            out_valid_q <= 1'b1;
            out_class_q <= best_class;
            out_count_q <= best;
            out_total_q <= total;
          end
        end
        ST_EMIT: begin
          if (handshake) begin
            for (int i = 0; i < NUM_CLASSES; i++) cnt[i] <= '0;
            out_valid_q <= 1'b0;
            total       <= '0;
            idx         <= '0;
            best        <= '0;
            best_class  <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dtc_vote_collector.sv
// tb/tb_dtc_vote_collector.sv - directed and randomized bench for dtc_vote_collector
module tb_dtc_vote_collector;
  import dtc_pkg::*;

  localparam int WINDOW = 16;
  localparam int CNT_W  = 8;
  localparam int LAT    = 9;

  typedef struct {
    int cnt [NUM_CLASSES];
    int wait_n;
    bit emit;
    int ec;
    int en;
    int et;
  } model_t;

  typedef struct packed {
    logic [CLASS_W-1:0] c;
    logic [CNT_W-1:0]   n;
    logic [CNT_W-1:0]   t;
  } res_t;

  logic   clk;
  logic   rst;
  int     n_checks;
  int     n_fail;
  model_t m;
  res_t   res_q [$];

  dtc_vote_collector_if #(.CNT_W(CNT_W)) bus ();

  dtc_vote_collector #(.WINDOW(WINDOW), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic void chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endfunction

  function automatic model_t model_zero();
    model_t z;
    for (int c = 0; c < NUM_CLASSES; c++) z.cnt[c] = 0;
    z.wait_n = 0;
    z.emit   = 1'b0;
    z.ec     = 0;
    z.en     = 0;
    z.et     = 0;
    return z;
  endfunction

  function automatic int model_sum(input model_t x);
    int s = 0;
    for (int c = 0; c < NUM_CLASSES; c++) s += x.cnt[c];
    return s;
  endfunction

  // Abstract view: a window fills, closes, the answer shows up LAT edges later, waits for pickup.
  function automatic model_t model_step(input model_t mi, input bit iv, input int ic,
                                        input bit fl, input bit ordy);
    model_t r = mi;
    int     tot;
    int     mx;
    if (r.emit) begin
      if (ordy) r = model_zero();
    end else if (r.wait_n > 0) begin
      r.wait_n--;
      if (r.wait_n == 0) r.emit = 1'b1;
    end else begin
      if (iv) r.cnt[ic]++;
      tot = model_sum(r);
      if (tot == WINDOW || (fl && tot > 0)) begin
        mx = 0;
        foreach (r.cnt[c]) if (r.cnt[c] > mx) mx = r.cnt[c];
        r.ec = -1;
        foreach (r.cnt[c]) if (r.ec < 0 && r.cnt[c] == mx) r.ec = c;
        r.en     = mx;
        r.et     = tot;
        r.wait_n = LAT;
      end
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    if (rst) m = model_zero();
    else     m = model_step(m, bus.in_valid, int'(bus.in_class), bus.flush, bus.out_ready);
    #2;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        chk("in_ready", int'(bus.in_ready), int'(!m.emit && m.wait_n == 0));
        chk("out_valid", int'(bus.out_valid), int'(m.emit));
        if (m.emit) begin
          chk("out_class", int'(bus.out_class), m.ec);
          chk("out_count", int'(bus.out_count), m.en);
          chk("out_total", int'(bus.out_total), m.et);
          chk("total_is_sum", int'(bus.out_total), model_sum(m));
        end
        if (bus.out_valid && bus.out_ready)
          res_q.push_back('{c: bus.out_class, n: bus.out_count, t: bus.out_total});
      end
    end
  end

  task automatic send(input int cls, input int n);
    for (int i = 0; i < n; i++) begin
      bus.in_valid = 1'b1;
      bus.in_class = CLASS_W'(cls);
      tick();
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_result(input int target, input string nm);
    int budget = 200;
    while (res_q.size() < target && budget > 0) begin
      tick();
      budget--;
    end
    chk({nm, "_arrived"}, int'(res_q.size() >= target), 1);
  endtask

  task automatic check_last(input string nm, input int c, input int n, input int t);
    if (res_q.size() > 0) begin
      chk({nm, "_class"}, int'(res_q[$].c), c);
      chk({nm, "_count"}, int'(res_q[$].n), n);
      chk({nm, "_total"}, int'(res_q[$].t), t);
    end
  endtask

  initial begin
    int seen;
    int target;
    int budget;
    n_checks      = 0;
    n_fail        = 0;
    m             = model_zero();
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_class  = '0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    chk("reset_in_ready", int'(bus.in_ready), 1);
    chk("reset_out_valid", int'(bus.out_valid), 0);
    chk("reset_out_class", int'(bus.out_class), 0);
    chk("reset_out_count", int'(bus.out_count), 0);
    chk("reset_out_total", int'(bus.out_total), 0);

    bus.out_ready = 1'b1;
    send(5, 10);
    send(2, 6);
    for (int n = 1; n <= LAT; n++) begin
      tick();
      chk($sformatf("latency_edge%0d", n), int'(bus.out_valid), int'(n == LAT));
    end
    wait_result(1, "majority");
    check_last("majority", 5, 10, 16);

    send(3, 8);
    send(1, 8);
    wait_result(2, "tie");
    check_last("tie", 1, 8, 16);

    send(4, 2);
    send(6, 1);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    wait_result(3, "flush");
    check_last("flush", 4, 2, 3);

    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.out_valid) seen++;
    end
    chk("flush_empty_no_result", seen, 0);

    bus.out_ready = 1'b0;
    send(7, 16);
    budget = 50;
    while (!bus.out_valid && budget > 0) begin
      tick();
      budget--;
    end
    chk("hold_reached_emit", int'(bus.out_valid), 1);
    bus.in_valid = 1'b1;
    bus.in_class = 3'd2;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("hold_in_ready", int'(bus.in_ready), 0);
      chk("hold_out_count", int'(bus.out_count), 16);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    wait_result(4, "hold");
    check_last("hold", 7, 16, 16);
    send(6, 16);
    wait_result(5, "after_hold");
    check_last("after_hold", 6, 16, 16);

    send(3, 7);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_in_ready", int'(bus.in_ready), 1);
    chk("midrst_out_valid", int'(bus.out_valid), 0);
    send(0, 16);
    wait_result(6, "after_rst");
    check_last("after_rst", 0, 16, 16);

    target = res_q.size() + 1000;
    budget = 90000;
    while (res_q.size() < target && budget > 0) begin
      bus.in_valid  = ($urandom_range(0, 9) < 7);
      bus.in_class  = CLASS_W'($urandom_range(0, 7));
      bus.flush     = ($urandom_range(0, 39) == 0);
      bus.out_ready = $urandom_range(0, 1) == 1;
      tick();
      budget--;
    end
    bus.in_valid = 1'b0;
    bus.flush    = 1'b0;
    chk("random_windows_done", int'(res_q.size() >= target), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
